// File: rtl/mod_counter_bcd.sv
// mod_counter_bcd: modulo-N up/down counter with cascade carry/borrow and
// a packed BCD view of the count, for chaining time-keeping fields.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   clr      synchronous clear to 0
//   load     synchronous load of data (rejected when data >= MODULUS)
//   data     preset value, binary
//   en       count enable (0 = hold)
//   up       direction: 1 = increment, 0 = decrement
//   count    registered binary count, 0..MODULUS-1
//   bcd      registered packed BCD of count, digit 0 in bits [3:0]
//   rco      combinational terminal-count pulse; drives next stage's en
//   load_err registered, high one cycle after a rejected load
module mod_counter_bcd #(
    parameter int unsigned MODULUS    = 60,
    parameter int unsigned WIDTH      = 6,
    parameter int unsigned BCD_DIGITS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      load,
    input  logic [WIDTH-1:0]          data,
    input  logic                      en,
    input  logic                      up,
    output logic [WIDTH-1:0]          count,
    output logic [4*BCD_DIGITS-1:0]   bcd,
    output logic                      rco,
    output logic                      load_err
);

    localparam int unsigned BW = 4 * BCD_DIGITS;

    // Elaboration-time helper: 10^n.
    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    // Elaboration-time helper: BCD of a constant (never used on the data path).
    function automatic logic [BW-1:0] const_bcd(input int unsigned v);
        logic [BW-1:0] b;
        int unsigned   r;
        b = '0;
        r = v;
        for (int unsigned d = 0; d < BCD_DIGITS; d++) begin
            b[4*d +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return b;
    endfunction

    // Combinational binary-to-BCD conversion (double-dabble) for loads.
    function automatic logic [BW-1:0] to_bcd(input logic [WIDTH-1:0] v);
        logic [BW+WIDTH-1:0] sr;
        sr = {{BW{1'b0}}, v};
        for (int unsigned i = 0; i < WIDTH; i++) begin
            for (int unsigned d = 0; d < BCD_DIGITS; d++) begin
                if (sr[WIDTH + 4*d +: 4] >= 4'd5) begin
                    sr[WIDTH + 4*d +: 4] = sr[WIDTH + 4*d +: 4] + 4'd3;
                end
            end
            sr = sr << 1;
        end
        return sr[WIDTH +: BW];
    endfunction

    // BCD +1 with decimal carry rippling through the digits.
    function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] b);
        logic [BW-1:0] r;
        logic          c;
        r = b;
        c = 1'b1;
        for (int unsigned d = 0; d < BCD_DIGITS; d++) begin
            if (c) begin
                if (r[4*d +: 4] == 4'd9) begin
                    r[4*d +: 4] = 4'd0;
                end else begin
                    r[4*d +: 4] = r[4*d +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // BCD -1 with decimal borrow rippling through the digits.
    function automatic logic [BW-1:0] bcd_dec(input logic [BW-1:0] b);
        logic [BW-1:0] r;
        logic          c;
        r = b;
        c = 1'b1;
        for (int unsigned d = 0; d < BCD_DIGITS; d++) begin
            if (c) begin
                if (r[4*d +: 4] == 4'd0) begin
                    r[4*d +: 4] = 4'd9;
                end else begin
                    r[4*d +: 4] = r[4*d +: 4] - 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Reject parameter sets the counter or its BCD view cannot represent.
    if (MODULUS < 2) begin : g_bad_mod_small
        $error("mod_counter_bcd: MODULUS must be at least 2");
    end
    if ((64'd1 << WIDTH) < 64'(MODULUS)) begin : g_bad_width
        $error("mod_counter_bcd: WIDTH too narrow for MODULUS");
    end
    if (64'(MODULUS) > pow10(BCD_DIGITS)) begin : g_bad_digits
        $error("mod_counter_bcd: BCD_DIGITS too few for MODULUS");
    end

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_X   = (WIDTH+1)'(MODULUS);
    localparam logic [BW-1:0]    MAX_BCD = const_bcd(MODULUS - 1);

    logic [WIDTH:0]   inc_x;
    logic [WIDTH:0]   dec_x;
    logic             load_ok;
    logic             at_top;
    logic             at_zero;
    logic [WIDTH-1:0] count_nxt;
    logic [BW-1:0]    bcd_nxt;
    logic             err_nxt;

    // Extended-width step: inc hitting MODULUS or dec borrowing out marks a wrap.
    assign inc_x   = {1'b0, count} + (WIDTH+1)'(1);
    assign dec_x   = {1'b0, count} - (WIDTH+1)'(1);
    assign load_ok = ({1'b0, data} < MOD_X);
    assign at_top  = (count == MAX_CNT);
    assign at_zero = (count == '0);

    // Cascade pulse: high in the cycle whose next edge wraps.
    assign rco = en & ~rst & ~clr & ~load & ((up & at_top) | (~up & at_zero));

    // Next-state: clr > load > en > hold; bcd tracks count step for step.
    always_comb begin
        count_nxt = count;
        bcd_nxt   = bcd;
        err_nxt   = 1'b0;
        if (clr) begin
            count_nxt = '0;
            bcd_nxt   = '0;
        end else if (load) begin
            if (load_ok) begin
                count_nxt = data;
                bcd_nxt   = to_bcd(data);
            end else begin
                err_nxt = 1'b1;
            end
        end else if (en) begin
            if (up) begin
                if (inc_x == MOD_X) begin
                    count_nxt = '0;
                    bcd_nxt   = '0;
                end else begin
                    count_nxt = inc_x[WIDTH-1:0];
                    bcd_nxt   = bcd_inc(bcd);
                end
            end else begin
                if (dec_x[WIDTH]) begin
                    count_nxt = MAX_CNT;
                    bcd_nxt   = MAX_BCD;
                end else begin
                    count_nxt = dec_x[WIDTH-1:0];
                    bcd_nxt   = bcd_dec(bcd);
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            bcd      <= '0;
            load_err <= 1'b0;
        end else begin
            count    <= count_nxt;
            bcd      <= bcd_nxt;
            load_err <= err_nxt;
        end
    end

endmodule

// File: tb/tb_mod_counter_bcd.sv
// Directed bench for mod_counter_bcd: a default mod-60 instance plus a
// minutes(60) -> hours(24) cascade.
module tb_mod_counter_bcd;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       load;
    logic [5:0] data;
    logic       en;
    logic       up;
    logic [5:0] count;
    logic [7:0] bcd;
    logic       rco;
    logic       load_err;

    logic       m_load;
    logic [5:0] m_data;
    logic       m_en;
    logic [5:0] m_count;
    logic [7:0] m_bcd;
    logic       m_rco;
    logic       m_err;
    logic       h_load;
    logic [4:0] h_data;
    logic [4:0] h_count;
    logic [7:0] h_bcd;
    logic       h_rco;
    logic       h_err;

    int n_vec;
    int n_err;

    mod_counter_bcd dut (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .data(data),
        .en(en), .up(up), .count(count), .bcd(bcd), .rco(rco),
        .load_err(load_err)
    );

    mod_counter_bcd #(.MODULUS(60), .WIDTH(6), .BCD_DIGITS(2)) u_min (
        .clk(clk), .rst(rst), .clr(1'b0), .load(m_load), .data(m_data),
        .en(m_en), .up(1'b1), .count(m_count), .bcd(m_bcd), .rco(m_rco),
        .load_err(m_err)
    );

    mod_counter_bcd #(.MODULUS(24), .WIDTH(5), .BCD_DIGITS(2)) u_hr (
        .clk(clk), .rst(rst), .clr(1'b0), .load(h_load), .data(h_data),
        .en(m_rco), .up(1'b1), .count(h_count), .bcd(h_bcd), .rco(h_rco),
        .load_err(h_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] dec2bcd(input int v);
        return 32'(((v / 10) << 4) | (v % 10));
    endfunction

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1; clr = 1'b0; load = 1'b0; data = '0; en = 1'b0; up = 1'b1;
        m_load = 1'b0; m_data = '0; m_en = 1'b0; h_load = 1'b0; h_data = '0;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_bcd", 32'(bcd), 32'h00);
        check("rst_err", 32'(load_err), 32'd0);

        // 1: count up through a full period
        tick();
        rst = 1'b0;
        en = 1'b1; up = 1'b1;
        #1;
        for (int i = 0; i < 60; i++) begin
            check("up_count", 32'(count), 32'(i));
            check("up_bcd", 32'(bcd), dec2bcd(i));
            check("up_rco", 32'(rco), (i == 59) ? 32'd1 : 32'd0);
            tick();
        end
        check("up_wrap_count", 32'(count), 32'd0);
        check("up_wrap_bcd", 32'(bcd), 32'h00);

        // 2: count down from reset; rco masked while rst is high
        rst = 1'b1; up = 1'b0; en = 1'b1;
        #1;
        check("dn_rco_in_rst", 32'(rco), 32'd0);
        rst = 1'b0;
        #1;
        check("dn_rco_zero", 32'(rco), 32'd1);
        tick();
        check("dn_wrap_count", 32'(count), 32'd59);
        check("dn_wrap_bcd", 32'(bcd), 32'h59);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("dn_bcd", 32'(bcd), dec2bcd(58 - i));
        end
        check("dn_count", 32'(count), 32'd49);
        check("dn_bcd49", 32'(bcd), 32'h49);

        // 3: good load, then rejected load with en high
        en = 1'b0; load = 1'b1; data = 6'd37; up = 1'b1;
        tick();
        check("ld_count", 32'(count), 32'd37);
        check("ld_bcd", 32'(bcd), 32'h37);
        check("ld_err", 32'(load_err), 32'd0);
        data = 6'd60; en = 1'b1;
        #1;
        check("ld_rco_masked", 32'(rco), 32'd0);
        tick();
        check("rej_count", 32'(count), 32'd37);
        check("rej_bcd", 32'(bcd), 32'h37);
        check("rej_err", 32'(load_err), 32'd1);
        load = 1'b0; en = 1'b0;
        tick();
        check("rej_err_clear", 32'(load_err), 32'd0);
        check("rej_hold", 32'(count), 32'd37);

        // 4: clr beats load beats en
        load = 1'b1; data = 6'd30;
        tick();
        check("pre30", 32'(count), 32'd30);
        clr = 1'b1; load = 1'b1; data = 6'd12; en = 1'b1;
        tick();
        check("clr_count", 32'(count), 32'd0);
        check("clr_bcd", 32'(bcd), 32'h00);
        clr = 1'b0;
        tick();
        check("ld_over_en", 32'(count), 32'd12);
        check("ld_over_en_bcd", 32'(bcd), 32'h12);

        // direction change and decimal carry/borrow across digits
        load = 1'b0; en = 1'b1; up = 1'b1;
        tick();
        check("dir_up", 32'(count), 32'd13);
        up = 1'b0;
        tick();
        check("dir_dn", 32'(count), 32'd12);
        load = 1'b1; data = 6'd10;
        tick();
        load = 1'b0;
        tick();
        check("borrow_bcd", 32'(bcd), 32'h09);
        load = 1'b1; data = 6'd19; up = 1'b1;
        tick();
        load = 1'b0;
        tick();
        check("carry_bcd", 32'(bcd), 32'h20);
        check("carry_count", 32'(count), 32'd20);

        // 5: minutes -> hours cascade wrap 23:59 -> 00:00
        en = 1'b0;
        m_load = 1'b1; m_data = 6'd59; h_load = 1'b1; h_data = 5'd23;
        tick();
        m_load = 1'b0; h_load = 1'b0;
        check("pre_min", 32'(m_bcd), 32'h59);
        check("pre_hr", 32'(h_bcd), 32'h23);
        m_en = 1'b1;
        #1;
        check("min_rco", 32'(m_rco), 32'd1);
        check("hr_rco", 32'(h_rco), 32'd1);
        tick();
        m_en = 1'b0;
        check("wrap_min", 32'(m_count), 32'd0);
        check("wrap_hr", 32'(h_count), 32'd0);
        check("wrap_hr_bcd", 32'(h_bcd), 32'h00);
        check("hr_rco_idle", 32'(h_rco), 32'd0);
        m_load = 1'b1; m_data = 6'd59; h_load = 1'b1; h_data = 5'd9;
        tick();
        m_load = 1'b0; h_load = 1'b0; m_en = 1'b1;
        #1;
        check("hr_rco_mid", 32'(h_rco), 32'd0);
        tick();
        m_en = 1'b0;
        check("hr_step", 32'(h_count), 32'd10);
        check("hr_step_bcd", 32'(h_bcd), 32'h10);
        check("min_step", 32'(m_count), 32'd0);
        check("hr_err", 32'(h_err | m_err), 32'd0);

        // 6: async reset mid-cycle
        load = 1'b1; data = 6'd45;
        tick();
        data = 6'd60;
        tick();
        check("pre_rst_err", 32'(load_err), 32'd1);
        check("pre_rst_count", 32'(count), 32'd45);
        load = 1'b0; en = 1'b1; up = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("async_count", 32'(count), 32'd0);
        check("async_bcd", 32'(bcd), 32'h00);
        check("async_err", 32'(load_err), 32'd0);
        #1;
        rst = 1'b0;
        #1;
        check("post_rst_hold", 32'(count), 32'd0);
        tick();
        check("post_rst_step", 32'(count), 32'd1);
        check("post_rst_bcd", 32'(bcd), 32'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mod_counter_bcd.md
Name: mod_counter_bcd

Overview:
Parametrised modulo-N up/down counter with cascade carry/borrow and a packed BCD view of the count. Generalises the fixed mod-60 seconds/minutes counter so one block serves seconds/minutes (60), hours (24/12), day-of-month and similar time-keeping fields. Instances chain rco into the next stage's en.

Parameters:
MODULUS, 60, count range 0..MODULUS-1; legal range 2..10^BCD_DIGITS.
WIDTH, 6, binary count width; must satisfy 2^WIDTH >= MODULUS.
BCD_DIGITS, 2, number of BCD digits presented on bcd.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous active-high reset.
clr  input  1  synchronous clear to 0.
load  input  1  synchronous load of data.
data  input  WIDTH  preset value (binary).
en  input  1  count enable (0 = hold).
up  input  1  direction: 1 = increment, 0 = decrement.
count  output  WIDTH  current value, binary, registered.
bcd  output  4*BCD_DIGITS  current value as packed BCD, digit 0 in bits [3:0], registered.
rco  output  1  combinational terminal-count/cascade pulse.
load_err  output  1  registered; high one cycle after a rejected load.

Behaviour:
- Reset (rst=1, async): count=0, bcd=0, load_err=0. rco evaluates to 0 while rst is high.
- Priority per rising edge: rst > clr > load > en > hold.
- clr=1: count<=0, bcd<=0, load_err<=0.
- load=1, clr=0, data<MODULUS: count<=data, bcd<=BCD(data), load_err<=0. The count value is visible the cycle after the edge, so latency is 1 cycle.
- load=1, clr=0, data>=MODULUS: the load is rejected. count and bcd hold, and load_err<=1 for exactly one cycle. en is ignored in that cycle (no count).
- en=1, up=1 (no clr/load): if count==MODULUS-1, count<=0; otherwise count<=count+1.
- en=1, up=0: if count==0, count<=MODULUS-1; otherwise count<=count-1.
- en=0: hold.
- load_err<=0 on every edge that is not a rejected load.
- bcd is maintained incrementally in lockstep with count, using per-digit +1/-1 with decimal carry/borrow across digits. On wrap it is set to 0 or BCD(MODULUS-1). No divider sits on the count path. The BCD(data) conversion for load is combinational (double-dabble). Invariant on every cycle: bcd == BCD(count).
- rco = en & ~rst & ~clr & ~load & ((up & count==MODULUS-1) | (~up & count==0)). It is high in the cycle whose next edge wraps, so a downstream stage with en=rco steps on the same edge.
- Changing direction (up toggled) takes effect on the next edge with no lost or extra step.
- Arithmetic is done in WIDTH+1 bits internally. count never holds a value >= MODULUS.
- Out-of-range parameters (2^WIDTH < MODULUS, or MODULUS > 10^BCD_DIGITS) are elaboration errors.

Test Plan:
1. Defaults. Reset, then en=1, up=1 for 60 cycles → count steps 0..59 then 0. bcd shows 0x59 at count 59. rco high only in the count==59 cycle, and the wrap to 0 lands on that edge.
2. Defaults, en=1, up=0 from reset → first edge gives count=59, bcd=0x59. rco is high in the count==0 cycle before that edge. A further 10 edges give count=49, bcd=0x49.
3. load=1 with data=37 → next cycle count=37, bcd=0x37, load_err=0. Then load=1 with data=60 and en=1 → count stays 37 and load_err=1 for one cycle, then 0.
4. Priority: clr=1, load=1, data=12, en=1 in the same cycle at count=30 → count=0, bcd=0x00. Then load=1, en=1, data=12 → count=12, with no increment applied.
5. MODULUS=24, WIDTH=5. Chain two instances (minutes mod60 feeding hours mod24): preload 23:59, then one en pulse → both wrap to 00:00 on the same edge, with the hours rco high in that cycle.
6. Assert rst asynchronously mid-cycle at count=45, en=1 → count, bcd and load_err go to 0 immediately without waiting for a clock edge. Release rst → counting resumes from 0 on the next edge.
